// File: rtl/draw_port_arbiter.sv
// draw_port_arbiter
//   Round-robin arbiter that shares the single framebuffer write port among
//   NUM_REQ pixel-draw requesters (background, platforms, doodle, monsters).
//   One requester is granted per burst. A burst ends on req_last or after
//   BURST_MAX accepted beats. Accepted beats go through one output register
//   stage that honours fb_ready backpressure. Beats addressed outside the
//   frame are consumed and dropped.
//
// Ports
//   Clk        system clock, rising edge
//   Reset      synchronous, active-high
//   req_valid  per-requester beat valid
//   req_last   per-requester final beat of burst
//   req_addr   per-requester pixel address, slice [i*ADDR_W +: ADDR_W]
//   req_color  per-requester palette index, slice [i*8 +: 8]
//   req_ready  per-requester beat accepted when valid & ready
//   fb_we      write beat present on fb_addr / fb_color
//   fb_addr    write address
//   fb_color   write data, bits [7:6] forced to 0
//   fb_ready   write port consumes the beat when fb_we & fb_ready
//   grant_id   requester currently or last granted
//   busy       1 while the FSM is in GRANT
//   state_dbg  raw FSM state (0 = IDLE, 1 = GRANT)
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. Valid never waits for ready; ready may depend combinationally on the
// downstream ready (req_ready follows fb_ready while the output register is
// full).

module draw_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 19,
  parameter int PIX_COUNT = 307200,
  parameter int BURST_MAX = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*8-1:0]        req_color,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        fb_we,
  output logic [ADDR_W-1:0]           fb_addr,
  output logic [7:0]                  fb_color,
  input  logic                        fb_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        state_dbg
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [ADDR_W:0]  PIX_LIM   = (ADDR_W + 1)'(PIX_COUNT);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  beat_cnt;

  logic              sel_valid;
  logic              sel_last;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_color;
  logic              out_free;
  logic              accept;
  logic              addr_ok;
  logic [CNT_W-1:0]  cnt_inc;

  logic              arb_found;
  logic [ID_W-1:0]   arb_idx;
  logic [ID_W-1:0]   arb_next;
  int                scan_idx;

  assign state_dbg = state;

  // Granted requester's beat and the output-register handshake.
  always_comb begin
    sel_valid = req_valid[grant_id];
    sel_last  = req_last[grant_id];
    sel_addr  = req_addr[grant_id*ADDR_W +: ADDR_W];
    sel_color = req_color[grant_id*8 +: 8];
    // The register can take a new beat when empty or draining this cycle.
    out_free  = !fb_we || fb_ready;
    accept    = (state == ST_GRANT) && sel_valid && out_free;
    addr_ok   = {1'b0, sel_addr} < PIX_LIM;
    cnt_inc   = beat_cnt + 1'b1;
    req_ready = '0;
    if (state == ST_GRANT) begin
      req_ready[grant_id] = out_free;
    end
  end

  // Round-robin search starting at rr_ptr. Scanning offsets from high to low
  // and overwriting on each hit leaves the smallest offset as the winner.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan_idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[scan_idx]) begin
        arb_found = 1'b1;
        arb_idx   = ID_W'(scan_idx);
      end
    end
    arb_next = ID_W'((int'(arb_idx) + 1) % NUM_REQ);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_color <= '0;
    end else begin
      // Output register drains independently of the FSM, so a beat held
      // under backpressure still completes after the grant has ended.
      if (accept && addr_ok) begin
        fb_we    <= 1'b1;
        fb_addr  <= sel_addr;
        fb_color <= {2'b00, sel_color[5:0]};
      end else if (fb_we && fb_ready) begin
        fb_we <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (arb_found) begin
            grant_id <= arb_idx;
            rr_ptr   <= arb_next;
            beat_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A requester dropping valid mid-burst keeps the grant; we wait.
          if (accept) begin
            beat_cnt <= cnt_inc;
            if (sel_last || (cnt_inc == BURST_LIM)) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_port_arbiter.sv
module tb_draw_port_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 19;
  localparam int PIX = 307200;
  localparam int BM  = 16;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_last;
  logic [NR*AW-1:0]     req_addr;
  logic [NR*8-1:0]      req_color;
  logic [NR-1:0]        req_ready;
  logic                 fb_we;
  logic [AW-1:0]        fb_addr;
  logic [7:0]           fb_color;
  logic                 fb_ready;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 state_dbg;

  draw_port_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .PIX_COUNT(PIX), .BURST_MAX(BM)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_color(req_color), .req_ready(req_ready),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_color(fb_color), .fb_ready(fb_ready),
    .grant_id(grant_id), .busy(busy), .state_dbg(state_dbg)
  );

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+7:0] exp_q[$];          // {addr, color} expected on the write port
  logic [AW+8:0] beat_q[NR][$];     // {last, addr, color} per requester
  int  grant_log[$];
  int  rise_cyc[$];
  bit  prev_busy, pend_release, pend_hold;
  int  cur_burst, n_accept, n_write;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int gl(input int k);
    return (k < grant_log.size()) ? grant_log[k] : -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    logic [AW+8:0] b;
    for (int i = 0; i < NR; i++) begin
      if (beat_q[i].size() > 0) begin
        b = beat_q[i][0];
        req_valid[i]           = 1'b1;
        req_last[i]            = b[AW+8];
        req_addr[i*AW +: AW]   = b[AW+7:8];
        req_color[i*8 +: 8]    = b[7:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic push_beat(input int id, input bit last, input int addr, input logic [7:0] color);
    logic [AW+8:0] b;
    b = {last, AW'(addr), color};
    beat_q[id].push_back(b);
  endtask

  // One clock: observe at the falling edge, update drives 1 time unit after
  // the rising edge.
  task automatic step();
    logic [NR-1:0] exp_rdy;
    logic [AW+8:0] b;
    logic [AW+7:0] e;
    @(negedge Clk);
    if (fb_we === 1'b1 && fb_ready) begin
      n_write++;
      if (exp_q.size() == 0) begin
        check("write_without_beat", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("fb_beat", {fb_addr, fb_color}, e);
      end
    end
    if (busy && !prev_busy) begin
      grant_log.push_back(grant_id);
      rise_cyc.push_back(cyc);
      cur_burst = 0;
    end
    prev_busy = busy;
    if (pend_release) check("busy_release", busy, 0);
    else if (pend_hold) check("busy_hold", busy, 1);
    pend_release = 0;
    pend_hold    = 0;
    exp_rdy = '0;
    if (busy && (!fb_we || fb_ready)) exp_rdy[grant_id] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i] && beat_q[i].size() > 0) begin
        b = beat_q[i].pop_front();
        n_accept++;
        cur_burst++;
        if (int'(b[AW+7:8]) < PIX) exp_q.push_back({b[AW+7:8], 2'b00, b[5:0]});
        if (b[AW+8] || cur_burst == BM) pend_release = 1;
        else pend_hold = 1;
      end
    end
    @(posedge Clk);
    #1;
    drive_inputs();
  endtask

  task automatic run_until_idle(input string tag, input int max);
    bit done;
    bit empty;
    done = 0;
    for (int n = 0; n < max; n++) begin
      empty = (exp_q.size() == 0);
      for (int i = 0; i < NR; i++) if (beat_q[i].size() > 0) empty = 0;
      if (empty && !busy && !fb_we) begin
        done = 1;
        break;
      end
      step();
    end
    check(tag, done, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_fb_we"},    fb_we, 0);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_grant"},    grant_id, 0);
    check({tag, "_ready"},    req_ready, 0);
    check({tag, "_addr"},     fb_addr, 0);
    check({tag, "_color"},    fb_color, 0);
    check({tag, "_state"},    state_dbg, 0);
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1;
    for (int i = 0; i < NR; i++) beat_q[i].delete();
    exp_q.delete();
    grant_log.delete();
    rise_cyc.delete();
    drive_inputs();
    prev_busy = 0; pend_release = 0; pend_hold = 0; cur_burst = 0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    check_reset_state(tag);
  endtask

  task automatic clear_counts();
    n_accept = 0;
    n_write  = 0;
    grant_log.delete();
    rise_cyc.delete();
  endtask

  // ---------------- directed sequence ----------------
  logic [AW-1:0] hold_a;
  logic [7:0]    hold_c;

  initial begin
    int exp_g[5];
    Reset     = 1'b1;
    fb_ready  = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_addr  = '0;
    req_color = '0;
    @(posedge Clk);
    #1;
    do_reset("rst0");

    // Test 1: three beats from req0, colour masked to 6 bits.
    clear_counts();
    push_beat(0, 0, 10, 8'hFF);
    push_beat(0, 0, 11, 8'hFF);
    push_beat(0, 1, 12, 8'hFF);
    drive_inputs();
    run_until_idle("t1_done", 40);
    check("t1_writes", n_write, 3);
    check("t1_grants", grant_log.size(), 1);
    check("t1_grant0", gl(0), 0);

    // Test 2: all four valid with single-beat bursts.
    do_reset("rst1");
    clear_counts();
    for (int i = 0; i < NR; i++) push_beat(i, 1, 100 + i, 8'(i * 17));
    push_beat(0, 1, 104, 8'h55);
    drive_inputs();
    run_until_idle("t2_done", 40);
    exp_g = '{0, 1, 2, 3, 0};
    check("t2_grants", grant_log.size(), 5);
    for (int k = 0; k < 5; k++) check($sformatf("t2_grant%0d", k), gl(k), exp_g[k]);
    for (int k = 1; k < 5; k++)
      check($sformatf("t2_gap%0d", k),
            (k < rise_cyc.size()) ? rise_cyc[k] - rise_cyc[k-1] : -1, 2);

    // Test 3: req1 streams 20 beats; forced release after 16, req2 gets a
    // turn, then req1 is granted again.
    clear_counts();
    for (int k = 0; k < 20; k++) push_beat(1, (k == 19), 200 + k, 8'(k));
    push_beat(2, 1, 300, 8'hAA);
    drive_inputs();
    run_until_idle("t3_done", 80);
    check("t3_grants", grant_log.size(), 3);
    check("t3_grant0", gl(0), 1);
    check("t3_grant1", gl(1), 2);
    check("t3_grant2", gl(2), 1);
    check("t3_writes", n_write, 21);

    // Test 4: backpressure for 5 cycles mid-burst.
    clear_counts();
    for (int k = 0; k < 6; k++) push_beat(0, (k == 5), 400 + k, 8'hC0 | 8'(k));
    drive_inputs();
    for (int n = 0; n < 10; n++) begin
      if (fb_we) break;
      step();
    end
    check("t4_we_seen", fb_we, 1);
    hold_a   = fb_addr;
    hold_c   = fb_color;
    fb_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      check("t4_we_stable", fb_we, 1);
      check("t4_addr_stable", fb_addr, hold_a);
      check("t4_color_stable", fb_color, hold_c);
      check("t4_ready_low", req_ready, 0);
    end
    fb_ready = 1'b1;
    run_until_idle("t4_done", 40);
    check("t4_accepts", n_accept, 6);
    check("t4_writes", n_write, 6);

    // Test 5: out-of-frame beat is accepted but never written.
    clear_counts();
    push_beat(1, 0, PIX - 1, 8'h12);
    push_beat(1, 0, PIX, 8'h34);
    push_beat(1, 1, 5, 8'h56);
    drive_inputs();
    run_until_idle("t5_done", 40);
    check("t5_accepts", n_accept, 3);
    check("t5_writes", n_write, 2);

    // Test 6: reset while a beat is stalled on the write port.
    clear_counts();
    for (int k = 0; k < 4; k++) push_beat(1, (k == 3), 600 + k, 8'h0F);
    fb_ready = 1'b0;
    drive_inputs();
    for (int n = 0; n < 10; n++) begin
      if (fb_we) break;
      step();
    end
    check("t6_stalled", fb_we, 1);
    check("t6_grant_pre", grant_id, 1);
    do_reset("t6_rst");
    fb_ready = 1'b1;
    clear_counts();
    push_beat(0, 1, 700, 8'h01);
    push_beat(2, 1, 701, 8'h02);
    drive_inputs();
    run_until_idle("t6_done", 40);
    check("t6_grant0", gl(0), 0);
    check("t6_grant1", gl(1), 2);
    check("t6_writes", n_write, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
